// File: rtl/pipe_hazard_fwd_unit_pkg.sv
// ----------------------------------------------------------------------------
// hazard_pkg
//   Shared types and constants for the pipeline hazard / forwarding unit.
//   - FWD_* : encodings of the EXE operand-forwarding mux select.
//   - sb_entry_t : one scoreboard slot describing an in-flight register write.
//   - RA_W_MAX : width of the dest field held in a scoreboard slot. Register
//     addresses narrower than this are zero-extended before being stored or
//     compared, so any RA_W up to RA_W_MAX is supported.
// ----------------------------------------------------------------------------
package hazard_pkg;

    localparam int RA_W_MAX = 8;

    // Forwarding mux encodings: 0 takes the regfile value, k+1 takes the
    // result sitting k stages past EXE.
    localparam int FWD_REGFILE = 0;
    localparam int FWD_EXE2MEM = 1;
    localparam int FWD_WB      = 2;

    typedef struct packed {
        logic                v;
        logic [RA_W_MAX-1:0] dest;
        logic                ld;
    } sb_entry_t;

    // Empty slot, used for bubbles and reset.
    function automatic sb_entry_t sb_bubble();
        sb_entry_t e;
        e.v    = 1'b0;
        e.dest = '0;
        e.ld   = 1'b0;
        return e;
    endfunction

endpackage

// File: rtl/pipe_hazard_fwd_unit_sb_match.sv
// ----------------------------------------------------------------------------
// sb_match
//   Combinational priority matcher over the scoreboard for one source operand.
//   Reports whether any valid entry writes the source register, the index of
//   the youngest such entry (lowest index = closest to EXE) and whether that
//   entry is a load. Reads of r0 or unused operands never match.
// Ports
//   entries  in   DEPTH x sb_entry_t  scoreboard, index 0 = EXE
//   src      in   RA_W_MAX            source register (zero-extended)
//   used     in   1                   operand is actually read
//   hit      out  1                   some entry matches
//   k        out  K_W                 index of the youngest matching entry
//   is_load  out  1                   youngest matching entry is a load
// ----------------------------------------------------------------------------
module sb_match
    import hazard_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int K_W   = 2
) (
    input  sb_entry_t           entries [DEPTH],
    input  logic [RA_W_MAX-1:0] src,
    input  logic                used,
    output logic                hit,
    output logic [K_W-1:0]      k,
    output logic                is_load
);

    // Scan from oldest to youngest so the last match written, i.e. the
    // youngest producer, is the one that sticks.
    always_comb begin
        hit     = 1'b0;
        k       = '0;
        is_load = 1'b0;
        if (used && (src != '0)) begin
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (entries[i].v && (entries[i].dest == src)) begin
                    hit     = 1'b1;
                    k       = K_W'(i);
                    is_load = entries[i].ld;
                end
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_fwd_unit.sv
// ----------------------------------------------------------------------------
// pipe_hazard_fwd_unit
//   Hazard detection and forwarding control for the 5-stage pipeline. Tracks
//   in-flight register writes from EXE up to (not including) WB in a shifting
//   scoreboard and, for the instruction in ID, decides whether to forward,
//   stall (load-use, or any RAW when FWD_EN=0) or flush IF on a taken branch.
//   Also keeps saturating stall and flush counters.
// Parameters
//   RA_W      register-address width (must not exceed hazard_pkg::RA_W_MAX)
//   DEPTH     scoreboard stages tracked (0 = EXE, 1 = MEM, ...)
//   LOAD_RDY  lowest scoreboard index at which load data can be forwarded
//   FWD_EN    1 = forwarding, 0 = stall on every RAW hazard
//   CNT_W     performance counter width
// Ports
//   clk, rst                 clock (rising edge), async active-low reset
//   id_valid                 ID holds a real instruction
//   id_src1/2, id_src1/2_used source registers and whether they are read
//   id_dest, id_wb_en        destination register and regfile write enable
//   id_mem_r_en              ID instruction is a load
//   id_br_taken              branch resolved taken in ID
//   stall                    comb: freeze PC/IF2ID, bubble into EXE
//   if_flush                 comb: flush IF2ID
//   exe_fwd_sel1/2           reg: operand sources for the instruction in EXE
//   sb_busy                  comb: scoreboard holds a valid write
//   stall_cnt, flush_cnt     saturating event counters
// ----------------------------------------------------------------------------
module pipe_hazard_fwd_unit
    import hazard_pkg::*;
#(
    parameter int RA_W     = 5,
    parameter int DEPTH    = 2,
    parameter int LOAD_RDY = 1,
    parameter int FWD_EN   = 1,
    parameter int CNT_W    = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       id_valid,
    input  logic [RA_W-1:0]            id_src1,
    input  logic [RA_W-1:0]            id_src2,
    input  logic                       id_src1_used,
    input  logic                       id_src2_used,
    input  logic [RA_W-1:0]            id_dest,
    input  logic                       id_wb_en,
    input  logic                       id_mem_r_en,
    input  logic                       id_br_taken,
    output logic                       stall,
    output logic                       if_flush,
    output logic [$clog2(DEPTH+1)-1:0] exe_fwd_sel1,
    output logic [$clog2(DEPTH+1)-1:0] exe_fwd_sel2,
    output logic                       sb_busy,
    output logic [CNT_W-1:0]           stall_cnt,
    output logic [CNT_W-1:0]           flush_cnt
);

    localparam int SEL_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    sb_entry_t           sb [DEPTH];
    sb_entry_t           sb_in;
    logic [RA_W_MAX-1:0] src1_ext;
    logic [RA_W_MAX-1:0] src2_ext;
    logic                hit1;
    logic                hit2;
    logic                ld1;
    logic                ld2;
    logic [SEL_W-1:0]    k1;
    logic [SEL_W-1:0]    k2;
    logic                stall1;
    logic                stall2;
    logic [SEL_W-1:0]    sel1_c;
    logic [SEL_W-1:0]    sel2_c;

    assign src1_ext = RA_W_MAX'(id_src1);
    assign src2_ext = RA_W_MAX'(id_src2);

    sb_match #(
        .DEPTH (DEPTH),
        .K_W   (SEL_W)
    ) u_match1 (
        .entries (sb),
        .src     (src1_ext),
        .used    (id_src1_used),
        .hit     (hit1),
        .k       (k1),
        .is_load (ld1)
    );

    sb_match #(
        .DEPTH (DEPTH),
        .K_W   (SEL_W)
    ) u_match2 (
        .entries (sb),
        .src     (src2_ext),
        .used    (id_src2_used),
        .hit     (hit2),
        .k       (k2),
        .is_load (ld2)
    );

    // Per-operand hazard resolution. With forwarding only a load whose data
    // is not yet available stalls; every other producer is forwarded from
    // the stage it currently occupies.
    always_comb begin
        stall1 = 1'b0;
        stall2 = 1'b0;
        sel1_c = SEL_W'(FWD_REGFILE);
        sel2_c = SEL_W'(FWD_REGFILE);
        if (FWD_EN != 0) begin
            stall1 = hit1 && ld1 && (int'(k1) < LOAD_RDY);
            stall2 = hit2 && ld2 && (int'(k2) < LOAD_RDY);
            if (hit1) begin
                sel1_c = k1 + SEL_W'(FWD_EXE2MEM);
            end
            if (hit2) begin
                sel2_c = k2 + SEL_W'(FWD_EXE2MEM);
            end
        end else begin
            stall1 = hit1;
            stall2 = hit2;
        end
    end

    assign stall    = id_valid & (stall1 | stall2);
    assign if_flush = id_valid & id_br_taken & ~stall;

    // A stalled instruction does not advance, so it must not be recorded;
    // r0 writes are dropped because r0 can never be a real dependency.
    always_comb begin
        sb_in = sb_bubble();
        if (id_valid && id_wb_en && (id_dest != '0) && !stall) begin
            sb_in.v    = 1'b1;
            sb_in.dest = RA_W_MAX'(id_dest);
            sb_in.ld   = id_mem_r_en;
        end
    end

    // Scoreboard advances every cycle; the oldest entry falls off into WB,
    // where the regfile bypass covers it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                sb[i] <= sb_bubble();
            end
        end else begin
            sb[0] <= sb_in;
            for (int i = 1; i < DEPTH; i++) begin
                sb[i] <= sb[i-1];
            end
        end
    end

    // Any valid slot is a pending write, since only writers are recorded.
    always_comb begin
        sb_busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            sb_busy = sb_busy | sb[i].v;
        end
    end

    // Selects follow the instruction into EXE; a stall or ID bubble sends a
    // bubble into EXE, which reads nothing forwarded.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exe_fwd_sel1 <= SEL_W'(FWD_REGFILE);
            exe_fwd_sel2 <= SEL_W'(FWD_REGFILE);
        end else if (id_valid && !stall) begin
            exe_fwd_sel1 <= sel1_c;
            exe_fwd_sel2 <= sel2_c;
        end else begin
            exe_fwd_sel1 <= SEL_W'(FWD_REGFILE);
            exe_fwd_sel2 <= SEL_W'(FWD_REGFILE);
        end
    end

    // Event counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (if_flush && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_fwd_unit.sv
// ----------------------------------------------------------------------------
// tb_pipe_hazard_fwd_unit
//   Drives one forwarding instance and one stall-only instance (small
//   counters, so saturation is reached) with the same ID stream. Expected
//   outputs come from a model that keeps, per instance, the list of writes
//   issued in the last DEPTH cycles and derives stall/select from the age of
//   the youngest producer of each source register.
// ----------------------------------------------------------------------------
module tb_pipe_hazard_fwd_unit;

    localparam int RA_W     = 5;
    localparam int DEPTH    = 2;
    localparam int LOAD_RDY = 1;
    localparam int SEL_W    = 2;
    localparam int CNT_W_F  = 32;
    localparam int CNT_W_L  = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            id_valid;
    logic [RA_W-1:0] id_src1;
    logic [RA_W-1:0] id_src2;
    logic            id_src1_used;
    logic            id_src2_used;
    logic [RA_W-1:0] id_dest;
    logic            id_wb_en;
    logic            id_mem_r_en;
    logic            id_br_taken;

    logic               f_stall, f_if_flush, f_sb_busy;
    logic [SEL_W-1:0]   f_sel1, f_sel2;
    logic [CNT_W_F-1:0] f_stall_cnt, f_flush_cnt;
    logic               l_stall, l_if_flush, l_sb_busy;
    logic [SEL_W-1:0]   l_sel1, l_sel2;
    logic [CNT_W_L-1:0] l_stall_cnt, l_flush_cnt;

    int tests = 0;
    int fails = 0;

    // Model state, index 0 = forwarding instance, 1 = stall-only instance.
    // Slot a holds the write issued a+1 cycles ago.
    bit     fl_v    [2][DEPTH];
    int     fl_dest [2][DEPTH];
    bit     fl_ld   [2][DEPTH];
    int     m_sel1  [2];
    int     m_sel2  [2];
    longint m_scnt  [2];
    longint m_fcnt  [2];
    longint cnt_max [2];

    pipe_hazard_fwd_unit #(
        .RA_W(RA_W), .DEPTH(DEPTH), .LOAD_RDY(LOAD_RDY), .FWD_EN(1), .CNT_W(CNT_W_F)
    ) dut_fwd (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_src1(id_src1), .id_src2(id_src2),
        .id_src1_used(id_src1_used), .id_src2_used(id_src2_used),
        .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
        .id_br_taken(id_br_taken),
        .stall(f_stall), .if_flush(f_if_flush),
        .exe_fwd_sel1(f_sel1), .exe_fwd_sel2(f_sel2), .sb_busy(f_sb_busy),
        .stall_cnt(f_stall_cnt), .flush_cnt(f_flush_cnt)
    );

    pipe_hazard_fwd_unit #(
        .RA_W(RA_W), .DEPTH(DEPTH), .LOAD_RDY(LOAD_RDY), .FWD_EN(0), .CNT_W(CNT_W_L)
    ) dut_leg (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_src1(id_src1), .id_src2(id_src2),
        .id_src1_used(id_src1_used), .id_src2_used(id_src2_used),
        .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
        .id_br_taken(id_br_taken),
        .stall(l_stall), .if_flush(l_if_flush),
        .exe_fwd_sel1(l_sel1), .exe_fwd_sel2(l_sel2), .sb_busy(l_sb_busy),
        .stall_cnt(l_stall_cnt), .flush_cnt(l_flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Age of the youngest in-flight write to src, or -1 if none.
    function automatic int youngest(int m, logic used, logic [RA_W-1:0] src);
        if (used !== 1'b1 || src == '0) return -1;
        for (int a = 0; a < DEPTH; a++) begin
            if (fl_v[m][a] && fl_dest[m][a] == int'(src)) return a;
        end
        return -1;
    endfunction

    task automatic model_comb(input int m, output bit st, output bit fl,
                              output int s1, output int s2);
        int a1;
        int a2;
        bit h1;
        bit h2;
        a1 = youngest(m, id_src1_used, id_src1);
        a2 = youngest(m, id_src2_used, id_src2);
        h1 = 1'b0;
        h2 = 1'b0;
        s1 = 0;
        s2 = 0;
        if (m == 0) begin
            if (a1 >= 0) begin
                s1 = a1 + 1;
                if (fl_ld[m][a1] && a1 < LOAD_RDY) h1 = 1'b1;
            end
            if (a2 >= 0) begin
                s2 = a2 + 1;
                if (fl_ld[m][a2] && a2 < LOAD_RDY) h2 = 1'b1;
            end
        end else begin
            h1 = (a1 >= 0);
            h2 = (a2 >= 0);
        end
        st = (id_valid === 1'b1) && (h1 || h2);
        fl = (id_valid === 1'b1) && (id_br_taken === 1'b1) && !st;
    endtask

    function automatic bit model_busy(int m);
        bit b = 1'b0;
        for (int a = 0; a < DEPTH; a++) b |= fl_v[m][a];
        return b;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int a = 0; a < DEPTH; a++) begin
                fl_v[m][a]    = 1'b0;
                fl_dest[m][a] = 0;
                fl_ld[m][a]   = 1'b0;
            end
            m_sel1[m] = 0;
            m_sel2[m] = 0;
            m_scnt[m] = 0;
            m_fcnt[m] = 0;
        end
    endtask

    task automatic model_clock();
        for (int m = 0; m < 2; m++) begin
            bit st;
            bit fl;
            int s1;
            int s2;
            model_comb(m, st, fl, s1, s2);
            m_sel1[m] = (id_valid === 1'b1 && !st) ? s1 : 0;
            m_sel2[m] = (id_valid === 1'b1 && !st) ? s2 : 0;
            if (st && m_scnt[m] < cnt_max[m]) m_scnt[m]++;
            if (fl && m_fcnt[m] < cnt_max[m]) m_fcnt[m]++;
            for (int a = DEPTH - 1; a > 0; a--) begin
                fl_v[m][a]    = fl_v[m][a-1];
                fl_dest[m][a] = fl_dest[m][a-1];
                fl_ld[m][a]   = fl_ld[m][a-1];
            end
            fl_v[m][0]    = (id_valid === 1'b1) && (id_wb_en === 1'b1) && (id_dest != '0) && !st;
            fl_dest[m][0] = int'(id_dest);
            fl_ld[m][0]   = (id_mem_r_en === 1'b1);
        end
    endtask

    task automatic check_output();
        bit st;
        bit fl;
        int s1;
        int s2;
        model_comb(0, st, fl, s1, s2);
        cmp("fwd_stall",     64'(f_stall),     64'(st));
        cmp("fwd_if_flush",  64'(f_if_flush),  64'(fl));
        cmp("fwd_sb_busy",   64'(f_sb_busy),   64'(model_busy(0)));
        cmp("fwd_sel1",      64'(f_sel1),      64'(m_sel1[0]));
        cmp("fwd_sel2",      64'(f_sel2),      64'(m_sel2[0]));
        cmp("fwd_stall_cnt", 64'(f_stall_cnt), 64'(m_scnt[0]));
        cmp("fwd_flush_cnt", 64'(f_flush_cnt), 64'(m_fcnt[0]));
        model_comb(1, st, fl, s1, s2);
        cmp("leg_stall",     64'(l_stall),     64'(st));
        cmp("leg_if_flush",  64'(l_if_flush),  64'(fl));
        cmp("leg_sb_busy",   64'(l_sb_busy),   64'(model_busy(1)));
        cmp("leg_sel1",      64'(l_sel1),      64'(m_sel1[1]));
        cmp("leg_sel2",      64'(l_sel2),      64'(m_sel2[1]));
        cmp("leg_stall_cnt", 64'(l_stall_cnt), 64'(m_scnt[1]));
        cmp("leg_flush_cnt", 64'(l_flush_cnt), 64'(m_fcnt[1]));
    endtask

    task automatic drive(input bit v, input int s1, input bit u1, input int s2, input bit u2,
                         input int d, input bit wb, input bit ld, input bit br);
        id_valid     = v;
        id_src1      = RA_W'(s1);
        id_src1_used = u1;
        id_src2      = RA_W'(s2);
        id_src2_used = u2;
        id_dest      = RA_W'(d);
        id_wb_en     = wb;
        id_mem_r_en  = ld;
        id_br_taken  = br;
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic apply_stimulus(input bit v, input int s1, input bit u1, input int s2, input bit u2,
                                  input int d, input bit wb, input bit ld, input bit br);
        drive(v, s1, u1, s2, u2, d, wb, ld, br);
        #1;
        check_output();
        tick();
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        cnt_max[0] = (64'd1 << CNT_W_F) - 1;
        cnt_max[1] = (64'd1 << CNT_W_L) - 1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_output();
        cmp("reset_fwd_stall_cnt", 64'(f_stall_cnt), 64'd0);
        rst = 1'b1;

        // add r3,r1,r2 then add r4,r3,r3: forwarded from EXE2MEM; the
        // stall-only instance holds the consumer for two cycles.
        apply_stimulus(1, 1, 1, 2, 1, 3, 1, 0, 0);
        drive(1, 3, 1, 3, 1, 4, 1, 0, 0);
        #1;
        check_output();
        cmp("t1_fwd_nostall", 64'(f_stall), 64'd0);
        cmp("t4_leg_stall_c1", 64'(l_stall), 64'd1);
        tick();
        cmp("t1_fwd_sel1", 64'(f_sel1), 64'd1);
        cmp("t1_fwd_sel2", 64'(f_sel2), 64'd1);
        #1;
        check_output();
        cmp("t4_leg_stall_c2", 64'(l_stall), 64'd1);
        cmp("t4_leg_sel1", 64'(l_sel1), 64'd0);
        tick();
        #1;
        check_output();
        cmp("t4_leg_stall_c3", 64'(l_stall), 64'd0);
        tick();
        nops(3);

        // lw r5 then add r6,r5,r1: one load-use bubble, then WB forward.
        apply_stimulus(1, 1, 1, 0, 0, 5, 1, 1, 0);
        drive(1, 5, 1, 1, 1, 6, 1, 0, 0);
        #1;
        check_output();
        cmp("t2_stall_c1", 64'(f_stall), 64'd1);
        tick();
        #1;
        check_output();
        cmp("t2_stall_c2", 64'(f_stall), 64'd0);
        tick();
        cmp("t2_sel1", 64'(f_sel1), 64'd2);
        cmp("t2_stall_cnt", 64'(f_stall_cnt), 64'd1);
        nops(3);

        // add r7 ; nop ; sub r8,r7,r2: producer is in MEM, forward from WB.
        apply_stimulus(1, 1, 1, 2, 1, 7, 1, 0, 0);
        nops(1);
        drive(1, 7, 1, 2, 1, 8, 1, 0, 0);
        #1;
        check_output();
        cmp("t3_nostall", 64'(f_stall), 64'd0);
        tick();
        cmp("t3_sel1", 64'(f_sel1), 64'd2);
        nops(3);

        // lw r9 then taken bne r9,r10: flush only once the stall clears.
        apply_stimulus(1, 1, 1, 0, 0, 9, 1, 1, 0);
        drive(1, 9, 1, 10, 1, 0, 0, 0, 1);
        #1;
        check_output();
        cmp("t5_flush_while_stall", 64'(f_if_flush), 64'd0);
        cmp("t5_stall", 64'(f_stall), 64'd1);
        tick();
        #1;
        check_output();
        cmp("t5_flush_after", 64'(f_if_flush), 64'd1);
        tick();
        cmp("t5_flush_cnt", 64'(f_flush_cnt), 64'd1);
        nops(3);

        // r0 writes (ALU and load) are never tracked.
        apply_stimulus(1, 1, 1, 2, 1, 0, 1, 0, 0);
        drive(1, 0, 1, 0, 1, 11, 1, 0, 0);
        #1;
        check_output();
        cmp("t6_r0_nostall", 64'(f_stall), 64'd0);
        tick();
        cmp("t6_r0_sel1", 64'(f_sel1), 64'd0);
        nops(3);
        apply_stimulus(1, 1, 1, 0, 0, 0, 1, 1, 0);
        cmp("t6_r0_ld_busy", 64'(f_sb_busy), 64'd0);
        apply_stimulus(1, 0, 1, 0, 1, 12, 1, 0, 0);
        nops(3);

        // Reset dropped in the middle of a load-use stall.
        apply_stimulus(1, 1, 1, 0, 0, 5, 1, 1, 0);
        drive(1, 5, 1, 5, 1, 6, 1, 0, 0);
        #1;
        check_output();
        cmp("t6_pre_rst_stall", 64'(f_stall), 64'd1);
        rst = 1'b0;
        model_reset();
        #1;
        cmp("t6_rst_stall", 64'(f_stall), 64'd0);
        cmp("t6_rst_busy", 64'(f_sb_busy), 64'd0);
        cmp("t6_rst_leg_stall", 64'(l_stall), 64'd0);
        cmp("t6_rst_leg_busy", 64'(l_sb_busy), 64'd0);
        check_output();
        rst = 1'b1;
        tick();
        nops(2);

        // Random instruction stream with a small register set for dense
        // hazards, plus one more asynchronous reset midway.
        for (int i = 0; i < 600; i++) begin
            bit v;
            bit wb;
            bit ld;
            v  = ($urandom_range(0, 3) != 0);
            wb = ($urandom_range(0, 1) != 0);
            ld = wb && ($urandom_range(0, 2) == 0);
            drive(v, int'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
                  int'($urandom_range(0, 7)), ($urandom_range(0, 1) != 0),
                  int'($urandom_range(0, 7)), wb, ld, ($urandom_range(0, 4) == 0));
            #1;
            check_output();
            if (i == 300) begin
                rst = 1'b0;
                model_reset();
                #1;
                check_output();
                rst = 1'b1;
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
